// File: rtl/hmac_seq_if.sv
// Word stream between a producer (master) and consumer (slave).
// A word transfers on every cycle where rvalid && rready; the master holds rdata stable while rvalid && !rready.
interface hmac_seq_if #(
  parameter int WordW = 32
);
  logic             rvalid;
  logic [WordW-1:0] rdata;
  logic             rready;

  modport master (output rvalid, output rdata, input rready);
  modport slave  (input rvalid, input rdata, output rready);
endinterface

// File: rtl/hmac_seq.sv
// HMAC-SHA256 sequencer: drives one sha2 engine through the inner hash H((K^ipad)||msg)
// and the outer hash H((K^opad)||inner_digest); with hmac_en=0 at start it is a plain pass-through.
module hmac_seq #(
  parameter int WordW      = 32,
  parameter int KeyWords   = 8,
  parameter int BlockWords = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      hmac_en,
  input  logic                      reg_hash_start,
  input  logic                      reg_hash_process,
  input  logic [63:0]               reg_msg_length,
  input  logic [KeyWords*WordW-1:0] secret_key,
  hmac_seq_if.slave                 msg_fifo,
  hmac_seq_if.master                sha,
  output logic                      sha_hash_start,
  output logic                      sha_hash_process,
  output logic [63:0]               sha_message_length,
  input  logic                      sha_hash_done,
  input  logic [8*WordW-1:0]        sha_digest,
  output logic                      hash_done_o,
  output logic                      idle_o,
  output logic [2:0]                dbg_state_o
);

  localparam int DigestWords = 8;
  localparam logic [WordW-1:0] IPAD = {(WordW/8){8'h36}};
  localparam logic [WordW-1:0] OPAD = {(WordW/8){8'h5c}};
  localparam logic [3:0] LAST_KEY_IDX = 4'(BlockWords - 1);
  localparam logic [3:0] LAST_DIG_IDX = 4'(DigestWords - 1);

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_INNER_KEY    = 3'd1,
    S_INNER_MSG    = 3'd2,
    S_INNER_WAIT   = 3'd3,
    S_OUTER_START  = 3'd4,
    S_OUTER_KEY    = 3'd5,
    S_OUTER_DIGEST = 3'd6,
    S_OUTER_WAIT   = 3'd7
  } state_t;

  state_t           r_state;
  logic             r_mode;
  logic [3:0]       r_cnt;
  logic             r_pending;
  logic             r_sha_start;
  logic             r_sha_process;
  logic             r_done;
  logic [63:0]      r_len;
  logic [WordW-1:0] r_inner [DigestWords];

  logic [WordW-1:0] w_key [BlockWords];
  logic             w_pt;
  logic             w_valid;
  logic             w_msg_ready;
  logic             w_fire;
  logic [WordW-1:0] w_data;

  // Key zero-padded to a full block.
  for (genvar g = 0; g < BlockWords; g++) begin : g_key
    if (g < KeyWords) begin : g_word
      assign w_key[g] = secret_key[g*WordW +: WordW];
    end else begin : g_zero
      assign w_key[g] = '0;
    end
  end

  always_comb begin
    w_pt        = (r_state == S_IDLE) && !r_mode;
    w_valid     = 1'b0;
    w_data      = '0;
    w_msg_ready = 1'b0;
    case (r_state)
      S_IDLE, S_INNER_MSG: begin
        if (w_pt || (r_state == S_INNER_MSG)) begin
          w_valid     = msg_fifo.rvalid;
          w_data      = msg_fifo.rdata;
          w_msg_ready = sha.rready;
        end
      end
      S_INNER_KEY: begin
        w_valid = 1'b1;
        w_data  = w_key[r_cnt] ^ IPAD;
      end
      S_OUTER_KEY: begin
        w_valid = 1'b1;
        w_data  = w_key[r_cnt] ^ OPAD;
      end
      S_OUTER_DIGEST: begin
        w_valid = 1'b1;
        w_data  = r_inner[r_cnt[2:0]];
      end
      default: begin
        w_valid = 1'b0;
      end
    endcase
    w_fire = w_valid && sha.rready;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state       <= S_IDLE;
      r_mode        <= 1'b0;
      r_cnt         <= '0;
      r_pending     <= 1'b0;
      r_sha_start   <= 1'b0;
      r_sha_process <= 1'b0;
      r_done        <= 1'b0;
      r_len         <= '0;
      for (int i = 0; i < DigestWords; i++) r_inner[i] <= '0;
    end else begin
      r_sha_start   <= 1'b0;
      r_sha_process <= 1'b0;
      r_done        <= 1'b0;
      if (r_state != S_IDLE && reg_hash_process) r_pending <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (reg_hash_start) begin
            r_mode      <= hmac_en;
            r_sha_start <= 1'b1;
            if (hmac_en) begin
              r_len   <= reg_msg_length + 64'd512;
              r_state <= S_INNER_KEY;
              r_cnt   <= '0;
            end else begin
              r_len <= reg_msg_length;
            end
          end else if (!r_mode) begin
            r_len <= reg_msg_length;
          end
          if (w_pt) begin
            r_sha_process <= reg_hash_process;
            r_done        <= sha_hash_done;
          end
        end
        S_INNER_KEY: begin
          if (w_fire) begin
            if (r_cnt == LAST_KEY_IDX) begin
              r_state <= S_INNER_MSG;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
        end
        S_INNER_MSG: begin
          if (r_pending) begin
            r_sha_process <= 1'b1;
            r_pending     <= 1'b0;
            r_state       <= S_INNER_WAIT;
            r_cnt         <= '0;
          end
        end
        S_INNER_WAIT: begin
          if (sha_hash_done) begin
            for (int i = 0; i < DigestWords; i++) r_inner[i] <= sha_digest[i*WordW +: WordW];
            r_sha_start <= 1'b1;
            r_len       <= 64'd768;
            r_state     <= S_OUTER_START;
            r_cnt       <= '0;
          end
        end
        S_OUTER_START: begin
          r_state <= S_OUTER_KEY;
          r_cnt   <= '0;
        end
        S_OUTER_KEY: begin
          if (w_fire) begin
            if (r_cnt == LAST_KEY_IDX) begin
              r_state <= S_OUTER_DIGEST;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
        end
        S_OUTER_DIGEST: begin
          if (w_fire) begin
            if (r_cnt == LAST_DIG_IDX) begin
              r_sha_process <= 1'b1;
              r_state       <= S_OUTER_WAIT;
              r_cnt         <= '0;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
        end
        S_OUTER_WAIT: begin
          if (sha_hash_done) begin
            r_done    <= 1'b1;
            r_pending <= 1'b0;
            r_state   <= S_IDLE;
            r_cnt     <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sha.rvalid         = w_valid;
  assign sha.rdata          = w_data;
  assign msg_fifo.rready    = w_msg_ready;
  assign sha_hash_start     = r_sha_start;
  assign sha_hash_process   = r_sha_process;
  assign sha_message_length = r_len;
  assign hash_done_o        = r_done;
  assign idle_o             = (r_state == S_IDLE) && !r_pending && !reg_hash_start;
  assign dbg_state_o        = r_state;

endmodule

// File: tb/tb_hmac_seq.sv
// Bench for hmac_seq: a toy sha2 stub behind the word port, a message FIFO model in front,
// and a scoreboard of expected words, lengths, process points and final digests.
module tb_hmac_seq;

  localparam logic [2:0]   ST_IDLE       = 3'd0;
  localparam logic [2:0]   ST_INNER_WAIT = 3'd3;
  localparam logic [2:0]   ST_OUTER_KEY  = 3'd5;
  localparam logic [255:0] TOY_IV        = {8{32'h6a09e667}};

  logic         clk, rst;
  logic         hmac_en, reg_hash_start, reg_hash_process;
  logic [63:0]  reg_msg_length;
  logic [255:0] secret_key;
  logic         sha_hash_start, sha_hash_process, sha_hash_done;
  logic [63:0]  sha_message_length;
  logic [255:0] sha_digest;
  logic         hash_done_o, idle_o;
  logic [2:0]   dbg_state;

  hmac_seq_if #(.WordW(32)) msg_if ();
  hmac_seq_if #(.WordW(32)) sha_if ();

  hmac_seq #(.WordW(32), .KeyWords(8), .BlockWords(16)) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .hmac_en            (hmac_en),
    .reg_hash_start     (reg_hash_start),
    .reg_hash_process   (reg_hash_process),
    .reg_msg_length     (reg_msg_length),
    .secret_key         (secret_key),
    .msg_fifo           (msg_if),
    .sha                (sha_if),
    .sha_hash_start     (sha_hash_start),
    .sha_hash_process   (sha_hash_process),
    .sha_message_length (sha_message_length),
    .sha_hash_done      (sha_hash_done),
    .sha_digest         (sha_digest),
    .hash_done_o        (hash_done_o),
    .idle_o             (idle_o),
    .dbg_state_o        (dbg_state)
  );

  typedef struct {
    logic [31:0] key0;
    bit          rand_hi;
    int          nmsg;
    int          rdy;
    bit          early;
    logic [31:0] exp_in0;
    logic [31:0] exp_out0;
  } vec_t;

  int checks = 0, failures = 0;
  int n_start = 0, n_proc = 0, n_done = 0;
  int rdy_mode = 3;

  logic [31:0]  exp_q[$];
  logic [63:0]  exp_len_q[$];
  int           exp_pc_q[$];
  logic [255:0] exp_dig_q[$];
  logic [31:0]  first_w_q[$];
  logic [31:0]  msg_src[$];
  logic [31:0]  cur_msg[$];

  logic [255:0] stub_h;
  logic [63:0]  stub_len;
  int           stub_cnt, done_cd;
  logic         prev_done, stall_prev, msg_fire, sha_fire;
  logic [31:0]  stall_data;

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=event expected=none", name);
  endtask

  function automatic logic [255:0] toy_step(input logic [255:0] h, input logic [31:0] w);
    logic [255:0] r;
    r = {h[223:0], h[255:224]};
    r[31:0]  = r[31:0] ^ ({w[26:0], w[31:27]} + 32'h9e3779b9);
    r[63:32] = r[63:32] + w;
    return r;
  endfunction

  function automatic logic [255:0] toy_fin(input logic [255:0] h, input logic [63:0] len);
    return h ^ {4{len}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- sha2 stub, FIFO driver and scoreboard monitor ----------------
  initial begin
    msg_if.rvalid = 1'b0;
    msg_if.rdata  = '0;
    sha_if.rready = 1'b0;
    sha_hash_done = 1'b0;
    sha_digest    = '0;
    stub_h = TOY_IV; stub_len = '0; stub_cnt = 0; done_cd = 0;
    prev_done = 1'b0; stall_prev = 1'b0; stall_data = '0;
    forever begin
      @(negedge clk);
      msg_fire = msg_if.rvalid && msg_if.rready;
      sha_fire = sha_if.rvalid && sha_if.rready;
      if (rst) begin
        stall_prev = 1'b0;
        done_cd    = 0;
        prev_done  = 1'b0;
      end else begin
        if (stall_prev) begin
          chk("stall_valid", 256'(sha_if.rvalid), 256'(1));
          chk("stall_data", 256'(sha_if.rdata), 256'(stall_data));
        end
        stall_prev = sha_if.rvalid && !sha_if.rready;
        stall_data = sha_if.rdata;
        if (sha_hash_start) begin
          n_start++;
          stub_h = TOY_IV; stub_cnt = 0; stub_len = sha_message_length;
          if (exp_len_q.size() == 0) flag("unexpected_start");
          else chk("msg_length", 256'(sha_message_length), 256'(exp_len_q.pop_front()));
        end
        if (sha_fire) begin
          if (stub_cnt == 0) first_w_q.push_back(sha_if.rdata);
          stub_h = toy_step(stub_h, sha_if.rdata);
          stub_cnt++;
          if (exp_q.size() == 0) flag("unexpected_word");
          else chk("sha_word", 256'(sha_if.rdata), 256'(exp_q.pop_front()));
        end
        if (sha_hash_process) begin
          n_proc++;
          done_cd = 4;
          if (exp_pc_q.size() == 0) flag("unexpected_process");
          else chk("process_word_count", 256'(stub_cnt), 256'(exp_pc_q.pop_front()));
        end
        if (hash_done_o) begin
          n_done++;
          chk("done_latency", 256'(prev_done), 256'(1));
          if (exp_dig_q.size() == 0) flag("unexpected_done");
          else chk("final_digest", sha_digest, exp_dig_q.pop_front());
        end
        prev_done = sha_hash_done;
      end
      tick();
      if (msg_fire && msg_src.size() != 0) void'(msg_src.pop_front());
      msg_if.rvalid = (msg_src.size() != 0);
      msg_if.rdata  = (msg_src.size() != 0) ? msg_src[0] : 32'h0;
      case (rdy_mode)
        0:       sha_if.rready = 1'b1;
        1:       sha_if.rready = ~sha_if.rready;
        2:       sha_if.rready = 1'($urandom_range(0, 1));
        default: sha_if.rready = 1'b0;
      endcase
      sha_hash_done = 1'b0;
      if (done_cd > 0) begin
        done_cd--;
        if (done_cd == 0) begin
          sha_hash_done = 1'b1;
          sha_digest    = toy_fin(stub_h, stub_len);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_pulse();
    tick();
    reg_hash_start = 1'b1;
    @(negedge clk);
    chk("start_not_same_cycle", 256'(sha_hash_start), 256'(0));
    tick();
    reg_hash_start = 1'b0;
    @(negedge clk);
    chk("start_delayed_1", 256'(sha_hash_start), 256'(1));
  endtask

  task automatic process_pulse(input bit check_delay);
    tick();
    reg_hash_process = 1'b1;
    @(negedge clk);
    if (check_delay) chk("process_not_same_cycle", 256'(sha_hash_process), 256'(0));
    tick();
    reg_hash_process = 1'b0;
    @(negedge clk);
    if (check_delay) chk("process_delayed_1", 256'(sha_hash_process), 256'(1));
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 2000 && msg_src.size() != 0; i++) @(negedge clk);
    if (msg_src.size() != 0) flag("timeout_msg_drain");
  endtask

  task automatic wait_done(input int tgt);
    for (int i = 0; i < 3000 && n_done < tgt; i++) @(negedge clk);
    if (n_done < tgt) flag("timeout_hash_done");
  endtask

  task automatic wait_state(input logic [2:0] s);
    int i;
    for (i = 0; i < 2000 && dbg_state != s; i++) @(negedge clk);
    if (dbg_state != s) flag("timeout_state");
  endtask

  // Expected stream of one HMAC operation over cur_msg.
  task automatic expect_hmac(input logic [255:0] key, input logic [63:0] len);
    logic [255:0] h, inner;
    logic [31:0]  w;
    h = TOY_IV;
    for (int i = 0; i < 16; i++) begin
      if (i < 8) w = key[32*i +: 32] ^ 32'h36363636;
      else       w = 32'h36363636;
      exp_q.push_back(w);
      h = toy_step(h, w);
    end
    foreach (cur_msg[i]) begin
      exp_q.push_back(cur_msg[i]);
      h = toy_step(h, cur_msg[i]);
    end
    exp_len_q.push_back(len + 64'd512);
    exp_pc_q.push_back(16 + cur_msg.size());
    inner = toy_fin(h, len + 64'd512);
    h = TOY_IV;
    for (int i = 0; i < 16; i++) begin
      if (i < 8) w = key[32*i +: 32] ^ 32'h5c5c5c5c;
      else       w = 32'h5c5c5c5c;
      exp_q.push_back(w);
      h = toy_step(h, w);
    end
    for (int i = 0; i < 8; i++) begin
      w = inner[32*i +: 32];
      exp_q.push_back(w);
      h = toy_step(h, w);
    end
    exp_len_q.push_back(64'd768);
    exp_pc_q.push_back(24);
    exp_dig_q.push_back(toy_fin(h, 64'd768));
  endtask

  task automatic run_hmac(input vec_t v);
    logic [255:0] key;
    int tgt;
    rdy_mode = v.rdy;
    cur_msg.delete();
    first_w_q.delete();
    for (int i = 0; i < v.nmsg; i++) cur_msg.push_back($urandom);
    key = '0;
    key[31:0] = v.key0;
    if (v.rand_hi) for (int i = 1; i < 8; i++) key[32*i +: 32] = $urandom;
    secret_key     = key;
    hmac_en        = 1'b1;
    reg_msg_length = 64'(v.nmsg * 32);
    expect_hmac(key, reg_msg_length);
    tgt = n_done + 1;
    start_pulse();
    if (v.early) begin
      process_pulse(1'b0);
    end else begin
      foreach (cur_msg[i]) msg_src.push_back(cur_msg[i]);
      wait_drain();
      process_pulse(1'b0);
    end
    wait_done(tgt);
    @(negedge clk);
    chk("idle_after_hmac", 256'(idle_o), 256'(1));
    chk("scoreboard_empty", 256'(exp_q.size()), 256'(0));
    if (first_w_q.size() != 2) begin
      flag("first_word_count");
    end else begin
      chk("inner_word0", 256'(first_w_q[0]), 256'(v.exp_in0));
      chk("outer_word0", 256'(first_w_q[1]), 256'(v.exp_out0));
    end
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs[3];

  initial begin
    int s0, d0, p0, tgt;
    vecs[0] = '{32'h00000000, 1'b0, 0, 0, 1'b1, 32'h36363636, 32'h5c5c5c5c};
    vecs[1] = '{32'hFFFFFFFF, 1'b1, 2, 1, 1'b0, 32'hC9C9C9C9, 32'hA3A3A3A3};
    vecs[2] = '{32'h12345678, 1'b1, 5, 2, 1'b0, 32'h2402604E, 32'h4E680A24};

    rst = 1'b1;
    hmac_en = 1'b0; reg_hash_start = 1'b0; reg_hash_process = 1'b0;
    reg_msg_length = 64'd96; secret_key = '0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_sha_rvalid", 256'(sha_if.rvalid), 256'(0));
    chk("reset_msg_rready", 256'(msg_if.rready), 256'(0));
    chk("reset_sha_start", 256'(sha_hash_start), 256'(0));
    chk("reset_sha_process", 256'(sha_hash_process), 256'(0));
    chk("reset_hash_done", 256'(hash_done_o), 256'(0));
    chk("reset_idle", 256'(idle_o), 256'(1));
    chk("reset_state", 256'(dbg_state), 256'(ST_IDLE));

    // Pass-through: 3 words, 96 bits.
    begin
      logic [255:0] h;
      rdy_mode = 0;
      cur_msg.delete();
      cur_msg.push_back(32'hDEADBEEF); cur_msg.push_back(32'h01234567); cur_msg.push_back(32'hA5A5A5A5);
      h = TOY_IV;
      foreach (cur_msg[i]) begin
        exp_q.push_back(cur_msg[i]);
        h = toy_step(h, cur_msg[i]);
      end
      exp_len_q.push_back(64'd96);
      exp_pc_q.push_back(3);
      exp_dig_q.push_back(toy_fin(h, 64'd96));
      tgt = n_done + 1;
      start_pulse();
      foreach (cur_msg[i]) msg_src.push_back(cur_msg[i]);
      wait_drain();
      process_pulse(1'b1);
      wait_done(tgt);
      @(negedge clk);
      chk("pt_scoreboard_empty", 256'(exp_q.size()), 256'(0));
    end

    // Table-driven HMAC runs.
    for (int i = 0; i < 3; i++) run_hmac(vecs[i]);

    // Second start during InnerWait (with hmac_en flipped) is ignored.
    begin
      logic [255:0] key;
      rdy_mode = 2;
      key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      secret_key = key; hmac_en = 1'b1; reg_msg_length = 64'd32;
      cur_msg.delete();
      cur_msg.push_back(32'h61626364);
      expect_hmac(key, 64'd32);
      s0 = n_start; d0 = n_done; tgt = n_done + 1;
      start_pulse();
      msg_src.push_back(cur_msg[0]);
      wait_drain();
      process_pulse(1'b0);
      wait_state(ST_INNER_WAIT);
      tick();
      hmac_en = 1'b0;
      reg_hash_start = 1'b1;
      @(negedge clk);
      chk("idle_while_busy", 256'(idle_o), 256'(0));
      tick();
      reg_hash_start = 1'b0;
      wait_done(tgt);
      repeat (20) @(negedge clk);
      chk("second_start_ignored", 256'(n_start - s0), 256'(2));
      chk("single_hash_done", 256'(n_done - d0), 256'(1));
    end

    // Asynchronous reset in the middle of OuterKey.
    begin
      rdy_mode = 0;
      secret_key = {8{32'h0F0F0F0F}}; hmac_en = 1'b1; reg_msg_length = 64'd0;
      cur_msg.delete();
      expect_hmac(secret_key, 64'd0);
      start_pulse();
      process_pulse(1'b0);
      wait_state(ST_OUTER_KEY);
      tick();
      rst = 1'b1;
      rdy_mode = 3;
      exp_q.delete(); exp_len_q.delete(); exp_pc_q.delete(); exp_dig_q.delete();
      tick();
      @(negedge clk);
      chk("midrst_sha_rvalid", 256'(sha_if.rvalid), 256'(0));
      chk("midrst_msg_rready", 256'(msg_if.rready), 256'(0));
      chk("midrst_sha_start", 256'(sha_hash_start), 256'(0));
      chk("midrst_sha_process", 256'(sha_hash_process), 256'(0));
      chk("midrst_length", 256'(sha_message_length), 256'(0));
      chk("midrst_hash_done", 256'(hash_done_o), 256'(0));
      chk("midrst_idle", 256'(idle_o), 256'(1));
      chk("midrst_state", 256'(dbg_state), 256'(ST_IDLE));
      s0 = n_start; p0 = n_proc; d0 = n_done;
      tick();
      rst = 1'b0;
      repeat (20) @(negedge clk);
      chk("post_rst_no_start", 256'(n_start - s0), 256'(0));
      chk("post_rst_no_process", 256'(n_proc - p0), 256'(0));
      chk("post_rst_no_done", 256'(n_done - d0), 256'(0));
      chk("post_rst_idle", 256'(idle_o), 256'(1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
